uart_mmio_ctrl: RTL and testbench



---
 rtl/uart_mmio_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: a 16-byte register window on the core data bus,
// a TX launcher with a one-entry pending byte, a one-byte RX buffer and a status word.
// Optional interrupt output enabled by defining UART_MMIO_IRQ_EN.
module uart_mmio_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_we,
  input  logic                  bus_re,
  output logic                  bus_hit,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
`ifdef UART_MMIO_IRQ_EN
  output logic                  irq,
`endif
  input  logic                  tx_done,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte
);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT
  } txState_e;

  txState_e   state_q;
  logic       txStart_q;
  logic [7:0] txData_q;
  logic [7:0] pendBuf_q;
  logic       txPending_q;
  logic       txOverflow_q;

  logic [7:0] rxBuf_q, rxBuf_d;
  logic       rxFull_q, rxFull_d;
  logic       rxOverrun_q, rxOverrun_d;

  logic       winHit;
  logic [1:0] regSel;
  logic       txWrite, ctrlWrite, rxRead, rxPop, busyWrite;
  logic [1:0] ieBits;
  logic [DATA_WIDTH-1:0] statusWord;
  logic       unusedBits;

  assign winHit    = (bus_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign regSel    = bus_addr[3:2];
  assign bus_hit   = winHit & (bus_we | bus_re);
  assign txWrite   = bus_we & winHit & (regSel == 2'd0);
  assign ctrlWrite = bus_we & winHit & (regSel == 2'd3);
  assign rxRead    = bus_re & winHit & (regSel == 2'd1);
  assign rxPop     = rxRead & rxFull_q;
  assign unusedBits = ^{bus_addr[1:0], bus_wdata};

  // A store while the launcher is busy goes to the pending slot, except when it
  // coincides with tx_done in TX_WAIT, where the FSM itself decides its fate.
  assign busyWrite = txWrite & (state_q != TX_IDLE) & ~((state_q == TX_WAIT) & tx_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      txStart_q    <= 1'b0;
      txData_q     <= 8'h00;
      pendBuf_q    <= 8'h00;
      txPending_q  <= 1'b0;
      txOverflow_q <= 1'b0;
    end else begin
      txStart_q <= 1'b0;
      if (ctrlWrite && bus_wdata[4]) begin
        txOverflow_q <= 1'b0;
      end
      case (state_q)
        TX_IDLE: begin
          if (txWrite) begin
            txData_q  <= bus_wdata[7:0];
            txStart_q <= 1'b1;
            state_q   <= TX_START;
          end
        end
        TX_START: begin
          state_q <= TX_WAIT;
        end
        default: begin
          if (tx_done) begin
            if (txPending_q) begin
              txData_q  <= pendBuf_q;
              txStart_q <= 1'b1;
              state_q   <= TX_START;
              if (txWrite) begin
                pendBuf_q <= bus_wdata[7:0];
              end else begin
                txPending_q <= 1'b0;
              end
            end else if (txWrite) begin
              txData_q  <= bus_wdata[7:0];
              txStart_q <= 1'b1;
              state_q   <= TX_START;
            end else begin
              state_q <= TX_IDLE;
            end
          end
        end
      endcase
      if (busyWrite) begin
        if (!txPending_q) begin
          pendBuf_q   <= bus_wdata[7:0];
          txPending_q <= 1'b1;
        end else begin
          txOverflow_q <= 1'b1;
        end
      end
    end
  end

  // A pop in the same cycle as a new byte frees the slot for it, so no overrun.
  always_comb begin
    rxBuf_d     = rxBuf_q;
    rxFull_d    = rxFull_q;
    rxOverrun_d = rxOverrun_q;
    if (ctrlWrite && bus_wdata[3]) begin
      rxOverrun_d = 1'b0;
    end
    if (rx_valid) begin
      if (!rxFull_q || rxPop) begin
        rxBuf_d  = rx_byte;
        rxFull_d = 1'b1;
      end else begin
        rxOverrun_d = 1'b1;
      end
    end else if (rxPop) begin
      rxFull_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxBuf_q     <= 8'h00;
      rxFull_q    <= 1'b0;
      rxOverrun_q <= 1'b0;
    end else begin
      rxBuf_q     <= rxBuf_d;
      rxFull_q    <= rxFull_d;
      rxOverrun_q <= rxOverrun_d;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  logic rxIe_q, txIe_q, irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxIe_q <= 1'b0;
      txIe_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrlWrite) begin
        rxIe_q <= bus_wdata[0];
        txIe_q <= bus_wdata[1];
      end
      irq_q <= (rxFull_q & rxIe_q) |
               ((state_q == TX_IDLE) & ~txPending_q & txIe_q);
    end
  end

  assign irq    = irq_q;
  assign ieBits = {txIe_q, rxIe_q};
`else
  assign ieBits = 2'b00;
`endif

  assign statusWord = {{(DATA_WIDTH-7){1'b0}}, ieBits, txOverflow_q, rxOverrun_q,
                       rxFull_q, txPending_q, (state_q != TX_IDLE)};

  always_comb begin
    bus_rdata = '0;
    if (bus_re && winHit) begin
      case (regSel)
        2'd1:    bus_rdata = {{(DATA_WIDTH-8){1'b0}}, rxBuf_q};
        2'd2:    bus_rdata = statusWord;
        default: bus_rdata = '0;
      endcase
    end
  end

  assign tx_start = txStart_q;
  assign tx_data  = txData_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we, bus_re;
  logic        bus_hit;
  logic [31:0] bus_rdata;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done, rx_valid;
  logic [7:0]  rx_byte;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  uart_mmio_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_hit(bus_hit), .bus_rdata(bus_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_byte(rx_byte)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the transmitter holds at most one byte in flight plus a queue of one pending byte.
  logic       mReady = 1'b0;
  logic       mBusy, mStartPulse, mOverflow, mRxFull, mOverrun;
  logic [7:0] mTxData, mRxBuf;
  logic [7:0] mPend[$];

  always @(posedge clk) begin : modelUpdate
    logic hit, txw, ctrlw, pop, done;
    logic [1:0] sel;
    hit   = (bus_addr[31:4] == BASE[31:4]);
    sel   = bus_addr[3:2];
    txw   = bus_we && hit && sel == 2'd0;
    ctrlw = bus_we && hit && sel == 2'd3;
    pop   = bus_re && hit && sel == 2'd1 && mRxFull;
    done  = tx_done && mBusy && !mStartPulse;
    if (rst) begin
      mReady = 1'b1; mBusy = 1'b0; mStartPulse = 1'b0; mTxData = 8'h00;
      mPend.delete(); mOverflow = 1'b0; mRxFull = 1'b0; mRxBuf = 8'h00; mOverrun = 1'b0;
    end else if (mReady) begin
      if (ctrlw && bus_wdata[4]) mOverflow = 1'b0;
      if (ctrlw && bus_wdata[3]) mOverrun = 1'b0;
      mStartPulse = 1'b0;
      if (!mBusy) begin
        if (txw) begin mTxData = bus_wdata[7:0]; mBusy = 1'b1; mStartPulse = 1'b1; end
      end else if (done) begin
        if (mPend.size() != 0) begin
          mTxData = mPend.pop_front();
          mStartPulse = 1'b1;
          if (txw) mPend.push_back(bus_wdata[7:0]);
        end else if (txw) begin
          mTxData = bus_wdata[7:0];
          mStartPulse = 1'b1;
        end else begin
          mBusy = 1'b0;
        end
      end else if (txw) begin
        if (mPend.size() == 0) mPend.push_back(bus_wdata[7:0]);
        else mOverflow = 1'b1;
      end
      if (rx_valid) begin
        if (!mRxFull || pop) begin mRxBuf = rx_byte; mRxFull = 1'b1; end
        else mOverrun = 1'b1;
      end else if (pop) begin
        mRxFull = 1'b0;
      end
    end
  end

  function automatic logic [31:0] expRdata();
    logic [31:0] r;
    r = 32'h0;
    if (bus_re && bus_addr[31:4] == BASE[31:4]) begin
      case (bus_addr[3:2])
        2'd1: r = {24'h0, mRxBuf};
        2'd2: r = {27'h0, mOverflow, mOverrun, mRxFull, (mPend.size() != 0), mBusy};
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mReady) begin
      checkOutput("model tx_start", {31'h0, tx_start}, {31'h0, mStartPulse});
      checkOutput("model tx_data", {24'h0, tx_data}, {24'h0, mTxData});
      checkOutput("model bus_hit", {31'h0, bus_hit},
                  {31'h0, (bus_addr[31:4] == BASE[31:4]) && (bus_we || bus_re)});
      checkOutput("model bus_rdata", bus_rdata, expRdata());
    end
  end

  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] off,
                               input logic [31:0] wd, input logic done,
                               input logic rv, input logic [7:0] rb);
    bus_addr  = BASE + {24'h0, off};
    bus_wdata = wd;
    bus_we    = we;
    bus_re    = re;
    tx_done   = done;
    rx_valid  = rv;
    rx_byte   = rb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus_we = 1'b0; bus_re = 1'b0; tx_done = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [7:0] off, input logic [31:0] expected);
    applyStimulus(1'b0, 1'b1, off, 32'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput(name, bus_rdata, expected);
    tick();
  endtask

  task automatic writeReg(input logic [7:0] off, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, off, data, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h00);
    tick(); tick();
    rst = 1'b0;

    readCheck("reset status", 8'h08, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle tx_start", {31'h0, tx_start}, 32'h0);
      tick();
    end

    // Single launch, one-cycle pulse, busy until tx_done.
    writeReg(8'h00, 32'h41);
    applyStimulus(1'b0, 1'b1, 8'h08, 32'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("launch tx_start", {31'h0, tx_start}, 32'h1);
    checkOutput("launch tx_data", {24'h0, tx_data}, 32'h41);
    checkOutput("busy status", bus_rdata, 32'h1);
    tick();
    readCheck("wait status", 8'h08, 32'h1);
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h00);
    tick();
    readCheck("done status", 8'h08, 32'h0);

    // Pending byte, overflow drop and overflow clear.
    writeReg(8'h00, 32'h44);
    tick();
    writeReg(8'h00, 32'h42);
    writeReg(8'h00, 32'h43);
    readCheck("overflow status", 8'h08, 32'h13);
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h00);
    tick();
    @(negedge clk);
    checkOutput("pending launch", {31'h0, tx_start}, 32'h1);
    checkOutput("pending data", {24'h0, tx_data}, 32'h42);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h00);
    tick();
    writeReg(8'h0C, 32'h10);
    readCheck("overflow cleared", 8'h08, 32'h0);

    // Overrun, pop and overrun clear.
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b1, 8'h55);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b1, 8'h66);
    tick();
    readCheck("overrun status", 8'h08, 32'hC);
    readCheck("rx pop first", 8'h04, 32'h55);
    readCheck("after pop status", 8'h08, 32'h8);
    writeReg(8'h0C, 32'h08);

    // Pop and arrival in the same cycle.
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b1, 8'h55);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h04, 32'h0, 1'b0, 1'b1, 8'h77);
    @(negedge clk);
    checkOutput("simul pop old", bus_rdata, 32'h55);
    tick();
    readCheck("simul full no overrun", 8'h08, 32'h4);
    readCheck("simul pop new", 8'h04, 32'h77);
    readCheck("stale rx read", 8'h04, 32'h77);
    readCheck("rx empty status", 8'h08, 32'h0);

    // Decode boundaries: out of window, low address bits, read-only write, TXDATA read.
    applyStimulus(1'b0, 1'b1, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("outside hit", {31'h0, bus_hit}, 32'h0);
    checkOutput("outside rdata", bus_rdata, 32'h0);
    tick();
    writeReg(8'h08, 32'hFF);
    readCheck("ro write ignored", 8'h0A, 32'h0);

    // Write with tx_done while pending is full: no overflow.
    writeReg(8'h00, 32'h61);
    tick();
    writeReg(8'h00, 32'h62);
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h63, 1'b1, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h08, 32'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("swap launch data", {24'h0, tx_data}, 32'h62);
    checkOutput("swap status", bus_rdata, 32'h3);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h00);
    tick();
    @(negedge clk);
    checkOutput("swap second data", {24'h0, tx_data}, 32'h63);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h00);
    tick();

    // Write+read together, then write with tx_done while pending is empty.
    applyStimulus(1'b1, 1'b1, 8'h00, 32'h71, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("we+re txdata read", bus_rdata, 32'h0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h72, 1'b1, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h08, 32'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("direct launch", {31'h0, tx_start}, 32'h1);
    checkOutput("direct data", {24'h0, tx_data}, 32'h72);
    checkOutput("direct status", bus_rdata, 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h00);
    tick();

    // Reset mid-transfer; a late tx_done must not relaunch.
    writeReg(8'h00, 32'h5A);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h00);
    tick();
    @(negedge clk);
    checkOutput("post reset tx_start", {31'h0, tx_start}, 32'h0);
    tick();
    readCheck("post reset status", 8'h08, 32'h0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
